// File: rtl/ps2_hex_entry.sv
// rtl/ps2_hex_entry.sv - PS/2 set-2 keyboard receiver that assembles hex keys into an 8-bit guess
module ps2_hex_entry #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clock,
   input  logic       reset_signal,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] entry,
   output logic [7:0] user_value,
   output logic       value_valid,
   output logic [1:0] digit_count,
   output logic       frame_error
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_s;
   logic                   data_s;
   logic                   clk_prev;
   logic                   fall;

   logic [1:0]    state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          parity_bit;
   logic [TW-1:0] timer;
   logic [7:0]    rx_byte;
   logic          rx_valid;

   logic          brk;
   logic          ext;
   logic          hex_hit;
   logic [3:0]    hex_nibble;

   // Synchronizers preset to 1 so reset looks like an idle bus, not a falling edge.
   always_ff @(posedge clock) begin
      if (reset_signal) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
         clk_prev  <= clk_s;
      end
   end

   assign clk_s  = clk_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];
   assign fall   = clk_prev & ~clk_s;

   always_ff @(posedge clock) begin
      if (reset_signal) begin
         state       <= ST_IDLE;
         bit_cnt     <= 3'd0;
         shift       <= 8'h00;
         parity_bit  <= 1'b0;
         timer       <= '0;
         rx_byte     <= 8'h00;
         rx_valid    <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         frame_error <= 1'b0;
         if (fall || state == ST_IDLE) timer <= '0;
         else                          timer <= timer + 1'b1;

         if (state != ST_IDLE && !fall && timer == TW'(TIMEOUT_CYCLES - 1)) begin
            state       <= ST_IDLE;
            frame_error <= 1'b1;
         end else if (fall) begin
            case (state)
               ST_IDLE: begin
                  if (!data_s) begin
                     state   <= ST_DATA;
                     bit_cnt <= 3'd0;
                  end
               end
               ST_DATA: begin
                  shift   <= {data_s, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= ST_PARITY;
               end
               ST_PARITY: begin
                  parity_bit <= data_s;
                  state      <= ST_STOP;
               end
               default: begin
                  state <= ST_IDLE;
                  if (data_s && (^{shift, parity_bit})) begin
                     rx_valid <= 1'b1;
                     rx_byte  <= shift;
                  end else begin
                     frame_error <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

   always_comb begin
      hex_hit    = 1'b1;
      hex_nibble = 4'h0;
      case (rx_byte)
         8'h45: hex_nibble = 4'h0;
         8'h16: hex_nibble = 4'h1;
         8'h1E: hex_nibble = 4'h2;
         8'h26: hex_nibble = 4'h3;
         8'h25: hex_nibble = 4'h4;
         8'h2E: hex_nibble = 4'h5;
         8'h36: hex_nibble = 4'h6;
         8'h3D: hex_nibble = 4'h7;
         8'h3E: hex_nibble = 4'h8;
         8'h46: hex_nibble = 4'h9;
         8'h1C: hex_nibble = 4'hA;
         8'h32: hex_nibble = 4'hB;
         8'h21: hex_nibble = 4'hC;
         8'h23: hex_nibble = 4'hD;
         8'h24: hex_nibble = 4'hE;
         8'h2B: hex_nibble = 4'hF;
         default: hex_hit = 1'b0;
      endcase
   end

   // Break-prefixed codes are key releases; they only clear the prefix flags.
   always_ff @(posedge clock) begin
      if (reset_signal) begin
         entry       <= 8'h00;
         user_value  <= 8'h00;
         value_valid <= 1'b0;
         digit_count <= 2'd0;
         brk         <= 1'b0;
         ext         <= 1'b0;
      end else begin
         value_valid <= 1'b0;
         if (rx_valid) begin
            if (rx_byte == 8'hE0) begin
               ext <= 1'b1;
            end else if (rx_byte == 8'hF0) begin
               brk <= 1'b1;
            end else if (brk) begin
               brk <= 1'b0;
               ext <= 1'b0;
            end else begin
               ext <= 1'b0;
               if (rx_byte == 8'h5A) begin
                  user_value  <= entry;
                  value_valid <= 1'b1;
                  entry       <= 8'h00;
                  digit_count <= 2'd0;
               end else if (rx_byte == 8'h66) begin
                  entry       <= {4'h0, entry[7:4]};
                  digit_count <= (digit_count == 2'd0) ? 2'd0 : digit_count - 2'd1;
               end else if (hex_hit && !ext) begin
                  entry       <= {entry[3:0], hex_nibble};
                  digit_count <= (digit_count == 2'd2) ? 2'd2 : digit_count + 2'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_hex_entry.sv
// tb/tb_ps2_hex_entry.sv - directed self-checking bench for ps2_hex_entry
module tb_ps2_hex_entry;

   localparam int TO = 200;

   logic       clock = 1'b0;
   logic       reset_signal = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] entry;
   logic [7:0] user_value;
   logic       value_valid;
   logic [1:0] digit_count;
   logic       frame_error;

   int checks = 0;
   int errors = 0;
   int vv_cycles = 0;
   int fe_cycles = 0;
   int vv_base;
   int fe_base;

   ps2_hex_entry #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
      .clock        (clock),
      .reset_signal (reset_signal),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .entry        (entry),
      .user_value   (user_value),
      .value_valid  (value_valid),
      .digit_count  (digit_count),
      .frame_error  (frame_error)
   );

   always #10 clock = ~clock;

   always @(posedge clock) begin
      if (value_valid) vv_cycles++;
      if (frame_error) fe_cycles++;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_bits(input logic [7:0] b, input int nbits, input logic par_ok, input logic stop);
      logic [10:0] fr;
      fr = {stop, (par_ok ? ~^b : ^b), b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = fr[i];
         idle(10);
         ps2_clk = 1'b0;
         idle(20);
         ps2_clk = 1'b1;
         idle(10);
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_key(input logic [7:0] b);
      send_bits(b, 11, 1'b1, 1'b1);
      idle(10);
   endtask

   task automatic test_reset;
      reset_signal = 1'b1;
      idle(4);
      reset_signal = 1'b0;
      idle(2);
      checks++; if (entry !== 8'h00) begin errors++; $display("FAIL reset_entry: got %h want 00", entry); end
      checks++; if (user_value !== 8'h00) begin errors++; $display("FAIL reset_user_value: got %h want 00", user_value); end
      checks++; if (value_valid !== 1'b0) begin errors++; $display("FAIL reset_value_valid: got %b want 0", value_valid); end
      checks++; if (digit_count !== 2'd0) begin errors++; $display("FAIL reset_digit_count: got %0d want 0", digit_count); end
      checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error: got %b want 0", frame_error); end
   endtask

   task automatic test_hex_entry;
      vv_base = vv_cycles;
      send_key(8'h2E);
      checks++; if (entry !== 8'h05) begin errors++; $display("FAIL hex_first: entry %h want 05", entry); end
      checks++; if (digit_count !== 2'd1) begin errors++; $display("FAIL hex_first_count: got %0d want 1", digit_count); end
      send_key(8'h1C);
      checks++; if (entry !== 8'h5A) begin errors++; $display("FAIL hex_second: entry %h want 5a", entry); end
      checks++; if (digit_count !== 2'd2) begin errors++; $display("FAIL hex_second_count: got %0d want 2", digit_count); end
      checks++; if (user_value !== 8'h00) begin errors++; $display("FAIL hex_user_value: got %h want 00", user_value); end
      checks++; if (vv_cycles - vv_base !== 0) begin errors++; $display("FAIL hex_no_valid: pulses %0d want 0", vv_cycles - vv_base); end
   endtask

   task automatic test_enter;
      vv_base = vv_cycles;
      send_key(8'h5A);
      send_key(8'hF0);
      send_key(8'h5A);
      checks++; if (user_value !== 8'h5A) begin errors++; $display("FAIL enter_value: got %h want 5a", user_value); end
      checks++; if (vv_cycles - vv_base !== 1) begin errors++; $display("FAIL enter_pulse: valid cycles %0d want 1", vv_cycles - vv_base); end
      checks++; if (entry !== 8'h00) begin errors++; $display("FAIL enter_entry: got %h want 00", entry); end
      checks++; if (digit_count !== 2'd0) begin errors++; $display("FAIL enter_count: got %0d want 0", digit_count); end
   endtask

   task automatic test_digits_backspace;
      send_key(8'h16);
      checks++; if (entry !== 8'h01) begin errors++; $display("FAIL digit_1: entry %h want 01", entry); end
      send_key(8'h1E);
      checks++; if (entry !== 8'h12) begin errors++; $display("FAIL digit_2: entry %h want 12", entry); end
      send_key(8'h26);
      checks++; if (entry !== 8'h23) begin errors++; $display("FAIL digit_3: entry %h want 23", entry); end
      checks++; if (digit_count !== 2'd2) begin errors++; $display("FAIL digit_saturate: count %0d want 2", digit_count); end
      send_key(8'h66);
      checks++; if (entry !== 8'h02) begin errors++; $display("FAIL backspace: entry %h want 02", entry); end
      checks++; if (digit_count !== 2'd1) begin errors++; $display("FAIL backspace_count: count %0d want 1", digit_count); end
   endtask

   task automatic test_frame_errors;
      fe_base = fe_cycles;
      send_bits(8'h16, 11, 1'b0, 1'b1);
      idle(10);
      send_bits(8'h16, 11, 1'b1, 1'b0);
      idle(10);
      checks++; if (fe_cycles - fe_base !== 2) begin errors++; $display("FAIL bad_frames: error cycles %0d want 2", fe_cycles - fe_base); end
      checks++; if (entry !== 8'h02) begin errors++; $display("FAIL bad_frames_entry: entry %h want 02", entry); end
      checks++; if (digit_count !== 2'd1) begin errors++; $display("FAIL bad_frames_count: count %0d want 1", digit_count); end
   endtask

   task automatic test_timeout;
      fe_base = fe_cycles;
      send_bits(8'h3D, 4, 1'b1, 1'b1);
      idle(TO + 50);
      checks++; if (fe_cycles - fe_base !== 1) begin errors++; $display("FAIL timeout_pulse: error cycles %0d want 1", fe_cycles - fe_base); end
      send_key(8'h45);
      checks++; if (fe_cycles - fe_base !== 1) begin errors++; $display("FAIL timeout_recover: error cycles %0d want 1", fe_cycles - fe_base); end
      checks++; if (entry !== 8'h20) begin errors++; $display("FAIL timeout_entry: entry %h want 20", entry); end
      checks++; if (digit_count !== 2'd2) begin errors++; $display("FAIL timeout_count: count %0d want 2", digit_count); end
   endtask

   task automatic test_reset_midframe;
      checks++; if (user_value !== 8'h5A) begin errors++; $display("FAIL pre_reset_value: got %h want 5a", user_value); end
      fe_base = fe_cycles;
      vv_base = vv_cycles;
      send_bits(8'h46, 5, 1'b1, 1'b1);
      reset_signal = 1'b1;
      idle(3);
      reset_signal = 1'b0;
      idle(2);
      checks++; if (entry !== 8'h00) begin errors++; $display("FAIL midreset_entry: got %h want 00", entry); end
      checks++; if (user_value !== 8'h00) begin errors++; $display("FAIL midreset_value: got %h want 00", user_value); end
      checks++; if (digit_count !== 2'd0) begin errors++; $display("FAIL midreset_count: got %0d want 0", digit_count); end
      idle(TO + 50);
      send_key(8'h46);
      checks++; if (entry !== 8'h09) begin errors++; $display("FAIL midreset_digit: entry %h want 09", entry); end
      checks++; if (digit_count !== 2'd1) begin errors++; $display("FAIL midreset_digit_count: count %0d want 1", digit_count); end
      checks++; if (fe_cycles - fe_base !== 0) begin errors++; $display("FAIL midreset_no_error: error cycles %0d want 0", fe_cycles - fe_base); end
      checks++; if (vv_cycles - vv_base !== 0) begin errors++; $display("FAIL midreset_no_valid: valid cycles %0d want 0", vv_cycles - vv_base); end
   endtask

   task automatic test_boundaries;
      send_key(8'hE0);
      send_key(8'h16);
      checks++; if (entry !== 8'h09) begin errors++; $display("FAIL ext_hex_ignored: entry %h want 09", entry); end
      send_key(8'h66);
      send_key(8'h66);
      checks++; if (entry !== 8'h00) begin errors++; $display("FAIL backspace_floor_entry: entry %h want 00", entry); end
      checks++; if (digit_count !== 2'd0) begin errors++; $display("FAIL backspace_floor_count: count %0d want 0", digit_count); end
      send_key(8'h3E);
      send_key(8'hF0);
      send_key(8'h3E);
      checks++; if (entry !== 8'h08) begin errors++; $display("FAIL break_ignored: entry %h want 08", entry); end
      send_key(8'h66);
      vv_base = vv_cycles;
      send_key(8'hE0);
      send_key(8'h5A);
      checks++; if (vv_cycles - vv_base !== 1) begin errors++; $display("FAIL empty_enter_pulse: valid cycles %0d want 1", vv_cycles - vv_base); end
      checks++; if (user_value !== 8'h00) begin errors++; $display("FAIL empty_enter_value: got %h want 00", user_value); end
   endtask

   initial begin
      test_reset;
      test_hex_entry;
      test_enter;
      test_digits_backspace;
      test_frame_errors;
      test_timeout;
      test_reset_midframe;
      test_boundaries;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
